// File: rtl/gprf_8x8.sv
// Ra8 general-purpose register file: eight DATA_W-bit registers, one synchronous
// write port and two independent combinational read ports with no write bypass.
module gprf_8x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] A_addr,
    output logic [DATA_W-1:0] A,
    input  logic [ADDR_W-1:0] B_addr,
    output logic [DATA_W-1:0] B
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            // NOTE: every element gets a value on every path, so no latch is inferred.
            regs_d[i] = regs_q[i];
            if (en && (writeAddr == ADDR_W'(i))) begin
                regs_d[i] = data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: this storage is reset on purpose; operands must read zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates, so reads in the same cycle see the old value.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports come straight off the flops: a write shows up only after its edge.
    assign A = regs_q[A_addr];
    assign B = regs_q[B_addr];

endmodule

// File: tb/tb_gprf_8x8.sv
// Self-checking bench for gprf_8x8: directed table vectors, multi-cycle corner
// sequences and randomized traffic checked against an array model of the registers.
module tb_gprf_8x8;

    typedef struct {
        logic [2:0] a_addr;
        logic [2:0] b_addr;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] writeAddr;
    logic [7:0] data;
    logic [2:0] A_addr;
    logic [7:0] A;
    logic [2:0] B_addr;
    logic [7:0] B;

    int vectors;
    int miscompares;

    logic [7:0] model [8];
    logic [7:0] fill_vals [8];
    vec_t       fill_tbl [5];

    gprf_8x8 #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .writeAddr (writeAddr),
        .data      (data),
        .A_addr    (A_addr),
        .A         (A),
        .B_addr    (B_addr),
        .B         (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [7:0] val);
        @(negedge clk);
        en        = 1'b1;
        writeAddr = addr;
        data      = val;
        @(posedge clk);
        model[addr] = val;
        #1;
        en = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 8; i++) do_write(3'(i), fill_vals[i]);
    endtask

    task automatic apply_fill_table(input string name, input bit expect_zero);
        for (int i = 0; i < 5; i++) begin
            A_addr = fill_tbl[i].a_addr;
            B_addr = fill_tbl[i].b_addr;
            #1;
            check({name, "_A"}, A, expect_zero ? 8'h00 : fill_tbl[i].exp_a);
            check({name, "_B"}, B, expect_zero ? 8'h00 : fill_tbl[i].exp_b);
        end
    endtask

    task automatic check_all_vs_model(input string name);
        for (int i = 0; i < 8; i++) begin
            A_addr = 3'(i);
            B_addr = 3'(7 - i);
            #1;
            check({name, "_A"}, A, model[i]);
            check({name, "_B"}, B, model[7 - i]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        fill_vals   = '{8'hF1, 8'hC4, 8'h9A, 8'h7E, 8'h55, 8'hAA, 8'h3C, 8'hE7};
        fill_tbl[0] = '{3'd0, 3'd7, 8'hF1, 8'hE7};
        fill_tbl[1] = '{3'd1, 3'd4, 8'hC4, 8'h55};
        fill_tbl[2] = '{3'd2, 3'd5, 8'h9A, 8'hAA};
        fill_tbl[3] = '{3'd3, 3'd6, 8'h7E, 8'h3C};
        fill_tbl[4] = '{3'd7, 3'd7, 8'hE7, 8'hE7};

        reset     = 1'b1;
        en        = 1'b0;
        writeAddr = 3'd0;
        data      = 8'h00;
        A_addr    = 3'd0;
        B_addr    = 3'd0;

        // Reset then read.
        #2 reset = 1'b0;
        clear_model();
        #1;
        check_all_vs_model("reset_read");
        @(negedge clk);
        reset = 1'b1;
        check_all_vs_model("post_reset_read");

        // Fill and read back through the table.
        fill_all();
        apply_fill_table("fill", 1'b0);

        // Write inhibit: en low must ignore address and data.
        @(negedge clk);
        en        = 1'b0;
        writeAddr = 3'd2;
        data      = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        A_addr = 3'd2;
        B_addr = 3'd2;
        #1;
        check("inhibit_A", A, 8'h9A);
        check("inhibit_B", B, 8'h9A);

        // Read and write the same register in one cycle.
        @(negedge clk);
        A_addr    = 3'd4;
        B_addr    = 3'd4;
        en        = 1'b1;
        writeAddr = 3'd4;
        data      = 8'h12;
        #1;
        check("rw_before_A", A, 8'h55);
        check("rw_before_B", B, 8'h55);
        @(posedge clk);
        model[4] = 8'h12;
        #1;
        en = 1'b0;
        check("rw_after_A", A, 8'h12);
        check("rw_after_B", B, 8'h12);
        check_all_vs_model("rw_others");

        // Reset asserted between edges after a fresh fill.
        fill_all();
        A_addr = 3'd5;
        B_addr = 3'd3;
        @(negedge clk);
        #1;
        check("pre_midreset_A", A, 8'hAA);
        check("pre_midreset_B", B, 8'h7E);
        reset = 1'b0;
        clear_model();
        #1;
        check("midreset_A", A, 8'h00);
        check("midreset_B", B, 8'h00);
        #1 reset = 1'b1;
        apply_fill_table("after_midreset", 1'b1);

        // Reset dominates a pending write.
        do_write(3'd1, 8'hC4);
        @(negedge clk);
        reset     = 1'b0;
        en        = 1'b1;
        writeAddr = 3'd1;
        data      = 8'hFF;
        A_addr    = 3'd1;
        B_addr    = 3'd1;
        @(posedge clk);
        #1;
        check("rst_vs_en_A", A, 8'h00);
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b1;
        clear_model();
        #1;
        check("rst_vs_en_after_A", A, 8'h00);
        check("rst_vs_en_after_B", B, 8'h00);

        // Random traffic against the array model, with occasional async resets.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            en        = 1'($urandom_range(0, 1));
            writeAddr = 3'($urandom_range(0, 7));
            data      = 8'($urandom_range(0, 255));
            A_addr    = 3'($urandom_range(0, 7));
            B_addr    = 3'($urandom_range(0, 7));
            #1;
            check("rand_pre_A", A, model[A_addr]);
            check("rand_pre_B", B, model[B_addr]);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                clear_model();
                #1;
                check("rand_rst_A", A, 8'h00);
                check("rand_rst_B", B, 8'h00);
                #1 reset = 1'b1;
            end
            @(posedge clk);
            if (en) model[writeAddr] = data;
            #1;
            check("rand_post_A", A, model[A_addr]);
            check("rand_post_B", B, model[B_addr]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
